// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter feeding the 1101 detector; valid/ready word load,
// MSB- or LSB-first output, gapless streaming across back-to-back words.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [0:0]    IDLE    = 1'b0;
  localparam logic [0:0]    SHIFT   = 1'b1;
  localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_M1 = CW'(WIDTH - 2);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             done_q;
  logic             last;
  logic             accept;
  logic [WIDTH-1:0] shifted;

  assign last       = (state == SHIFT) && (cnt == LAST);
  assign load_ready = (state == IDLE) || last;
  assign accept     = load_valid && load_ready;

  // Zero fill means the register is empty once a word drains, so sout idles at 0.
  assign shifted = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                    : {1'b0, shreg[WIDTH-1:1]};

  assign sout       = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
  assign sout_valid = state[0];
  assign busy       = state[0];
  assign done       = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else if (accept) begin
      state  <= SHIFT;
      shreg  <= din;
      cnt    <= '0;
      done_q <= 1'b0;
    end else if (state == SHIFT) begin
      shreg <= shifted;
      if (last) begin
        state  <= IDLE;
        cnt    <= '0;
        done_q <= 1'b0;
      end else begin
        cnt    <= cnt + ONE;
        // done is registered: raise it on the edge entering the last-bit cycle
        done_q <= (cnt == LAST_M1);
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share stimulus and
// are checked against a bit-queue reference model plus directed stream checks.
module tb_bit_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         load_valid = 1'b0;
  logic         rdy_m, sout_m, sv_m, busy_m, done_m;
  logic         rdy_l, sout_l, sv_l, busy_l, done_l;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: pending output bits in emission order, one queue per bit order.
  bit qm[$];
  bit ql[$];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(rdy_m), .sout(sout_m), .sout_valid(sv_m), .busy(busy_m), .done(done_m));

  bit_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(rdy_l), .sout(sout_l), .sout_valid(sv_l), .busy(busy_l), .done(done_l));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] ev, es_m, es_l, ed, er;
    ev   = 32'(qm.size() > 0);
    es_m = (qm.size() > 0) ? 32'(qm[0]) : 32'd0;
    es_l = (ql.size() > 0) ? 32'(ql[0]) : 32'd0;
    ed   = 32'(qm.size() == 1);
    er   = 32'(qm.size() <= 1);
    chk({tag, "_sout_m"},  32'(sout_m), es_m);
    chk({tag, "_valid_m"}, 32'(sv_m),   ev);
    chk({tag, "_busy_m"},  32'(busy_m), ev);
    chk({tag, "_done_m"},  32'(done_m), ed);
    chk({tag, "_ready_m"}, 32'(rdy_m),  er);
    chk({tag, "_sout_l"},  32'(sout_l), es_l);
    chk({tag, "_valid_l"}, 32'(sv_l),   ev);
    chk({tag, "_done_l"},  32'(done_l), ed);
    chk({tag, "_ready_l"}, 32'(rdy_l),  er);
  endtask

  // One clock: decide acceptance from pre-edge inputs, advance model, check #1 later.
  task automatic cyc(input string tag, output bit acc);
    logic [W-1:0] d;
    acc = load_valid && (qm.size() <= 1);
    d   = din;
    @(posedge clk);
    if (qm.size() > 0) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
    end
    if (acc)
      for (int i = 0; i < W; i++) begin
        qm.push_back(d[W-1-i]);
        ql.push_back(d[i]);
      end
    #1;
    check_all(tag);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_sout"},  {30'd0, sout_m, sout_l}, 32'd0);
    chk({tag, "_valid"}, {30'd0, sv_m, sv_l},     32'd0);
    chk({tag, "_busy"},  {30'd0, busy_m, busy_l}, 32'd0);
    chk({tag, "_done"},  {30'd0, done_m, done_l}, 32'd0);
    chk({tag, "_ready"}, {30'd0, rdy_m, rdy_l},   32'd3);
  endtask

  // Present w for one accept, then run n cycles collecting both streams and ready.
  // After cycle swap_at the producer raises load_valid with w2; it drops after accepts.
  task automatic stream(input string tag, input logic [W-1:0] w, input logic [W-1:0] w2,
                        input int n, input int swap_at,
                        output logic [31:0] bm, output logic [31:0] bl,
                        output logic [31:0] rm, output int acc2_idx);
    bit acc;
    bm = '0; bl = '0; rm = '0; acc2_idx = -1;
    din = w;
    load_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      cyc(tag, acc);
      if (acc && i > 0 && acc2_idx < 0) acc2_idx = i;
      bm[n-1-i] = sout_m;
      bl[n-1-i] = sout_l;
      rm[i]     = rdy_m;
      if (acc) load_valid = 1'b0;
      if (i == swap_at) begin
        load_valid = 1'b1;
        din = w2;
      end
    end
    load_valid = 1'b0;
  endtask

  function automatic logic [31:0] match_ends(input logic [31:0] s, input int n);
    logic [31:0] m;
    logic [3:0]  win;
    m = '0; win = '0;
    for (int i = 0; i < n; i++) begin
      win = {win[2:0], s[n-1-i]};
      if (i >= 3 && win == 4'b1101) m[i] = 1'b1;
    end
    return m;
  endfunction

  initial begin
    logic [31:0] bm, bl, rm;
    logic [W-1:0] w;
    int a2;
    bit acc;

    // Reset asserted from time 0, released mid-clock at 100 ns
    #50;
    check_reset_state("rst_hold");
    #50;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cyc("post_rst", acc);

    stream("d0", 8'hD0, 8'h00, 9, -1, bm, bl, rm, a2);
    chk("d0_msb_stream", bm, 32'h1A0);
    chk("d0_lsb_stream", bl, 32'h016);

    stream("lsb", 8'h0B, 8'h00, 9, -1, bm, bl, rm, a2);
    chk("0b_lsb_stream", bl, 32'h1A0);
    chk("0b_msb_stream", bm, 32'h016);

    stream("b2b", 8'hB6, 8'hD5, 17, 0, bm, bl, rm, a2);
    chk("b2b_stream", bm, 32'h16DAA);
    chk("b2b_ready", rm & 32'hFFFF, 32'h8080);
    chk("b2b_accept_idx", 32'(a2), 32'd8);
    chk("b2b_1101_ends", match_ends(bm >> 1, 16), 32'h920);

    stream("hold", 8'h5A, 8'hFF, 17, 2, bm, bl, rm, a2);
    chk("hold_stream", bm, 32'h0B5FE);
    chk("hold_accept_idx", 32'(a2), 32'd8);

    // Reset dropped mid-cycle while bit 4 of D0 is on the wire
    din = 8'hD0;
    load_valid = 1'b1;
    cyc("rmid", acc);
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) cyc("rmid", acc);
    chk("rmid_bit4", 32'(sout_m), 32'd0);
    chk("rmid_valid_before", 32'(sv_m), 32'd1);
    #2 rst = 1'b0;
    #1;
    qm.delete();
    ql.delete();
    check_reset_state("rmid_async");
    #20;
    check_reset_state("rmid_hold");
    rst = 1'b1;
    cyc("rmid_post", acc);
    w = W'($urandom);
    stream("rmid_new", w, 8'h00, 9, -1, bm, bl, rm, a2);
    chk("rmid_new_stream", bm, {23'd0, w, 1'b0});

    // Randomized traffic: random valid duty and din churn while busy
    for (int i = 0; i < 600; i++) begin
      load_valid = ($urandom_range(0, 3) != 0);
      din = W'($urandom);
      cyc("rand", acc);
    end
    load_valid = 1'b0;
    for (int i = 0; i < W + 2; i++) cyc("drain", acc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
